// File: rtl/multicycle_ctrl_pkg.sv
// multicycle_ctrl_pkg: opcode constants, FSM state enum and decoded-control bundle
package multicycle_ctrl_pkg;
    localparam int OP_R_TYPE = 0;
    localparam int OP_LI     = 1;
    localparam int OP_LW     = 2;
    localparam int OP_SW     = 3;
    localparam int OP_BNEZ   = 4;
    localparam int OP_SHIFT  = 5;
    localparam int OP_J      = 6;
    localparam int OP_JAL    = 7;
    typedef enum logic [2:0] {IDLE, EXEC, MEM, WB, FAULT} ctrl_state_t;
    typedef struct packed {
        logic wr;
        logic alu_src_imm;
        logic mem_to_reg;
        logic branch;
        logic jump;
        logic is_jal;
        logic update_flags;
        logic is_mem;
        logic is_store;
    } ctrl_bits_t;
    localparam int CTRL_W = $bits(ctrl_bits_t);
endpackage

// File: rtl/multicycle_ctrl_op_table.sv
// ctrl_op_table: combinational map from latched opcode to static control bits
//   i_op   : latched opcode
//   o_ctrl : packed ctrl_bits_t; undefined opcodes decode to all zeros (NOP)
module ctrl_op_table
    import multicycle_ctrl_pkg::*;
#(
    parameter int OPCODE_W = 3
) (
    input  logic [OPCODE_W-1:0] i_op,
    output logic [CTRL_W-1:0]   o_ctrl
);
    ctrl_bits_t w_c;
    always_comb begin
        w_c = '0;
        case (i_op)
            OPCODE_W'(OP_R_TYPE): begin
                w_c.wr           = 1'b1;
                w_c.update_flags = 1'b1;
            end
            OPCODE_W'(OP_LI): begin
                w_c.wr          = 1'b1;
                w_c.alu_src_imm = 1'b1;
            end
            OPCODE_W'(OP_LW): begin
                w_c.wr          = 1'b1;
                w_c.alu_src_imm = 1'b1;
                w_c.mem_to_reg  = 1'b1;
                w_c.is_mem      = 1'b1;
            end
            OPCODE_W'(OP_SW): begin
                w_c.alu_src_imm = 1'b1;
                w_c.is_mem      = 1'b1;
                w_c.is_store    = 1'b1;
            end
            OPCODE_W'(OP_BNEZ): w_c.branch = 1'b1;
            OPCODE_W'(OP_SHIFT): begin
                w_c.wr           = 1'b1;
                w_c.update_flags = 1'b1;
            end
            OPCODE_W'(OP_J): w_c.jump = 1'b1;
            OPCODE_W'(OP_JAL): begin
                w_c.wr     = 1'b1;
                w_c.jump   = 1'b1;
                w_c.is_jal = 1'b1;
            end
            default: w_c = '0;
        endcase
    end
    assign o_ctrl = w_c;
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: IDLE/EXEC/MEM/WB sequencer driving decoded controls and a memory handshake
//   clk, reset (sync, active-high) ; instr_valid/instr_ready/opcode : fetch handshake
//   mem_req/mem_we/mem_ack : memory handshake ; reg_write..update_flags : decoded controls
//   pc_en : retire pulse ; busy : not IDLE ; fault : sticky memory timeout
//   Macro CTRL_MEM_TIMEOUT_EN adds a MEM-wait counter and a FAULT state.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int OPCODE_W    = 3,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                instr_valid,
    output logic                instr_ready,
    input  logic [OPCODE_W-1:0] opcode,
    output logic                mem_req,
    output logic                mem_we,
    input  logic                mem_ack,
    output logic                reg_write,
    output logic                alu_src_imm,
    output logic                mem_to_reg,
    output logic                branch,
    output logic                jump,
    output logic                is_jal,
    output logic                update_flags,
    output logic                pc_en,
    output logic                busy,
    output logic                fault
);
    ctrl_state_t         r_state, w_next;
    logic [OPCODE_W-1:0] r_op;
    logic [CTRL_W-1:0]   w_bits;
    ctrl_bits_t          w_c;
    logic                w_act;
    logic                w_tmo;

    ctrl_op_table #(.OPCODE_W(OPCODE_W)) u_op_table (
        .i_op   (r_op),
        .o_ctrl (w_bits)
    );
    assign w_c = ctrl_bits_t'(w_bits);

`ifdef CTRL_MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
    logic [CNT_W-1:0] r_cnt;
    always_ff @(posedge clk) begin
        if (reset || r_state != MEM) r_cnt <= '0;
        else r_cnt <= r_cnt + 1'b1;
    end
    // r_cnt holds the number of MEM cycles already spent; the last allowed one is MEM_TIMEOUT-1
    assign w_tmo = !mem_ack && r_cnt == CNT_W'(MEM_TIMEOUT - 1);
`else
    logic [31:0] w_unused_timeout;
    assign w_unused_timeout = 32'(MEM_TIMEOUT);
    assign w_tmo = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_op    <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && instr_valid) r_op <= opcode;
        end
    end

    // Outputs are gated by reset so they read 0 during the reset cycle itself
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = instr_valid ? EXEC : IDLE;
            EXEC:    w_next = w_c.is_mem ? MEM : WB;
            MEM:     w_next = mem_ack ? WB : (w_tmo ? FAULT : MEM);
            WB:      w_next = IDLE;
            default: w_next = r_state;
        endcase
        w_act        = !reset && (r_state == EXEC || r_state == MEM || r_state == WB);
        instr_ready  = !reset && r_state == IDLE;
        busy         = !reset && r_state != IDLE;
        mem_req      = !reset && r_state == MEM;
        mem_we       = mem_req && w_c.is_store;
        reg_write    = !reset && r_state == WB && w_c.wr;
        pc_en        = !reset && r_state == WB;
        fault        = !reset && r_state == FAULT;
        alu_src_imm  = w_act && w_c.alu_src_imm;
        mem_to_reg   = w_act && w_c.mem_to_reg;
        branch       = w_act && w_c.branch;
        jump         = w_act && w_c.jump;
        is_jal       = w_act && w_c.is_jal;
        update_flags = w_act && w_c.update_flags;
    end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: randomized self-checking bench against a phase-level reference model
module tb_multicycle_ctrl;
    localparam int PH_IDLE  = 0;
    localparam int PH_EXEC  = 1;
    localparam int PH_MEM   = 2;
    localparam int PH_WB    = 3;
    localparam int PH_FAULT = 4;
    localparam int PH_RST   = 5;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       instr_valid = 1'b0;
    logic [3:0] opcode = '0;
    logic       mem_ack = 1'b0;
    logic       instr_ready, mem_req, mem_we, reg_write, alu_src_imm, mem_to_reg;
    logic       branch, jump, is_jal, update_flags, pc_en, busy, fault;
    int         n_pass = 0;
    int         n_total = 0;

    multicycle_ctrl #(.OPCODE_W(4), .MEM_TIMEOUT(15)) dut (
        .clk          (clk),
        .reset        (reset),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .opcode       (opcode),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_ack      (mem_ack),
        .reg_write    (reg_write),
        .alu_src_imm  (alu_src_imm),
        .mem_to_reg   (mem_to_reg),
        .branch       (branch),
        .jump         (jump),
        .is_jal       (is_jal),
        .update_flags (update_flags),
        .pc_en        (pc_en),
        .busy         (busy),
        .fault        (fault)
    );

    always #5 clk = ~clk;

    function automatic logic [12:0] obs();
        return {instr_ready, busy, mem_req, mem_we, reg_write, alu_src_imm, mem_to_reg,
                branch, jump, is_jal, update_flags, pc_en, fault};
    endfunction

    // Expected output vector for an instruction phase, built from the opcode rules
    function automatic logic [12:0] model(input int ph, input int op);
        bit       st  = op == 3;
        bit       wr  = op inside {0, 1, 2, 5, 7};
        bit [5:0] sc  = {op inside {1, 2, 3}, op == 2, op == 4, op inside {6, 7}, op == 7, op inside {0, 5}};
        bit       act = ph inside {PH_EXEC, PH_MEM, PH_WB};
        return {ph == PH_IDLE, ph inside {PH_EXEC, PH_MEM, PH_WB, PH_FAULT}, ph == PH_MEM,
                ph == PH_MEM && st, ph == PH_WB && wr, act ? sc : 6'b0, ph == PH_WB, ph == PH_FAULT};
    endfunction

    // One full instruction: accept, EXEC, d MEM cycles (ack in the d-th) for LW/SW, WB
    task automatic do_instr(input int op, input int d, input string tag);
        logic [12:0] e;
        @(negedge clk);
        instr_valid = 1'b1; opcode = 4'(op); mem_ack = 1'($urandom);
        #1 e = model(PH_IDLE, op); n_total++;
        if (obs() !== e) $display("FAIL %s accept op=%0d got=%b exp=%b", tag, op, obs(), e); else n_pass++;
        @(negedge clk);
        instr_valid = 1'($urandom); opcode = 4'($urandom); mem_ack = 1'($urandom);
        #1 e = model(PH_EXEC, op); n_total++;
        if (obs() !== e) $display("FAIL %s exec op=%0d got=%b exp=%b", tag, op, obs(), e); else n_pass++;
        if (op == 2 || op == 3) begin
            for (int k = 1; k <= d; k++) begin
                @(negedge clk);
                instr_valid = 1'($urandom); opcode = 4'($urandom); mem_ack = (k == d);
                #1 e = model(PH_MEM, op); n_total++;
                if (obs() !== e) $display("FAIL %s mem%0d op=%0d got=%b exp=%b", tag, k, op, obs(), e); else n_pass++;
            end
        end
        @(negedge clk);
        instr_valid = 1'($urandom); opcode = 4'($urandom); mem_ack = 1'($urandom);
        #1 e = model(PH_WB, op); n_total++;
        if (obs() !== e) $display("FAIL %s wb op=%0d got=%b exp=%b", tag, op, obs(), e); else n_pass++;
    endtask

    task automatic test_reset();
        logic [12:0] e;
        reset = 1'b1; instr_valid = 1'b1; mem_ack = 1'b1; opcode = 4'd2;
        repeat (2) @(negedge clk);
        #1 e = model(PH_RST, 0); n_total++;
        if (obs() !== e) $display("FAIL reset_hold got=%b exp=%b", obs(), e); else n_pass++;
        @(negedge clk);
        reset = 1'b0; instr_valid = 1'b0; mem_ack = 1'b0;
        #1 e = model(PH_IDLE, 0); n_total++;
        if (obs() !== e) $display("FAIL reset_release got=%b exp=%b", obs(), e); else n_pass++;
    endtask

    task automatic test_li();
        do_instr(1, 0, "li");
    endtask

    task automatic test_lw();
        do_instr(2, 4, "lw_ack4");
    endtask

    task automatic test_sw();
        do_instr(3, 1, "sw_ack1");
    endtask

    task automatic test_undef();
        do_instr(15, 0, "undef_f");
        do_instr(8, 0, "undef_8");
    endtask

    task automatic test_back_to_back();
        logic [12:0] e;
        for (int i = 0; i < 60; i++) begin
            do_instr(int'($urandom_range(0, 15)), int'($urandom_range(1, 6)), "rand");
            for (int g = int'($urandom_range(0, 2)); g > 0; g--) begin
                @(negedge clk);
                instr_valid = 1'b0; mem_ack = 1'($urandom); opcode = 4'($urandom);
                #1 e = model(PH_IDLE, 0); n_total++;
                if (obs() !== e) $display("FAIL gap got=%b exp=%b", obs(), e); else n_pass++;
            end
        end
    endtask

    task automatic test_reset_mid_mem();
        logic [12:0] e;
        @(negedge clk);
        instr_valid = 1'b1; opcode = 4'd2; mem_ack = 1'b0;
        @(negedge clk);
        instr_valid = 1'b0; opcode = 4'd0;
        #1 e = model(PH_EXEC, 2); n_total++;
        if (obs() !== e) $display("FAIL rstmem exec got=%b exp=%b", obs(), e); else n_pass++;
        @(negedge clk);
        #1 e = model(PH_MEM, 2); n_total++;
        if (obs() !== e) $display("FAIL rstmem mem1 got=%b exp=%b", obs(), e); else n_pass++;
        @(negedge clk);
        reset = 1'b1;
        #1 e = model(PH_RST, 2); n_total++;
        if (obs() !== e) $display("FAIL rstmem in_reset got=%b exp=%b", obs(), e); else n_pass++;
        @(negedge clk);
        reset = 1'b0; mem_ack = 1'b1;
        #1 e = model(PH_IDLE, 0); n_total++;
        if (obs() !== e) $display("FAIL rstmem after got=%b exp=%b", obs(), e); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            mem_ack = 1'($urandom);
            #1 e = model(PH_IDLE, 0); n_total++;
            if (obs() !== e) $display("FAIL rstmem stray_ack got=%b exp=%b", obs(), e); else n_pass++;
        end
        mem_ack = 1'b0;
    endtask

`ifdef CTRL_MEM_TIMEOUT_EN
    task automatic test_timeout();
        logic [12:0] e;
        @(negedge clk);
        instr_valid = 1'b1; opcode = 4'd2; mem_ack = 1'b0;
        @(negedge clk);
        instr_valid = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            #1 e = model(PH_MEM, 2); n_total++;
            if (obs() !== e) $display("FAIL tmo mem%0d got=%b exp=%b", k, obs(), e); else n_pass++;
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            instr_valid = 1'($urandom); mem_ack = 1'($urandom);
            #1 e = model(PH_FAULT, 2); n_total++;
            if (obs() !== e) $display("FAIL tmo fault%0d got=%b exp=%b", i, obs(), e); else n_pass++;
        end
        @(negedge clk);
        reset = 1'b1; instr_valid = 1'b0; mem_ack = 1'b0;
        #1 e = model(PH_RST, 0); n_total++;
        if (obs() !== e) $display("FAIL tmo reset got=%b exp=%b", obs(), e); else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        #1 e = model(PH_IDLE, 0); n_total++;
        if (obs() !== e) $display("FAIL tmo release got=%b exp=%b", obs(), e); else n_pass++;
    endtask
`else
    task automatic test_long_wait();
        do_instr(2, 30, "lw_wait30");
    endtask
`endif

    initial begin
        test_reset();
        test_li();
        test_lw();
        test_sw();
        test_undef();
        test_back_to_back();
        test_reset_mid_mem();
`ifdef CTRL_MEM_TIMEOUT_EN
        test_timeout();
`else
        test_long_wait();
`endif
        do_instr(7, 0, "jal_after");
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter OPCODE_W, default 3, sets opcode width; values above the defined opcode set are legal inputs.
REQ-002 Parameter MEM_TIMEOUT, default 15, sets the memory-wait limit in cycles (used only under REQ-030).
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 instr_valid  in  1  opcode offered by fetch.
REQ-006 instr_ready  out  1  controller accepts an opcode this cycle.
REQ-007 opcode  in  OPCODE_W  instruction opcode, sampled on handshake.
REQ-008 mem_req  out  1  memory request, held until acknowledged.
REQ-009 mem_we  out  1  request is a store; valid only while mem_req=1.
REQ-010 mem_ack  in  1  memory completion, one-cycle pulse.
REQ-011 reg_write, alu_src_imm, mem_to_reg, branch, jump, is_jal, update_flags  out  1 each  decoded controls per opcode (R_TYPE, LI, LW, SW, BNEZ, SHIFT, J, JAL).
REQ-012 pc_en  out  1  one-cycle pulse per retired instruction.
REQ-013 busy  out  1  high whenever state is not IDLE.
REQ-014 fault  out  1  sticky memory-timeout flag.

Function
REQ-015 States: IDLE, EXEC, MEM, WB; FAULT exists only under REQ-030.
REQ-016 IDLE: instr_ready=1; on instr_valid=1, opcode latches into an internal register and the FSM moves to EXEC.
REQ-017 EXEC lasts one cycle; LW/SW go to MEM; every other opcode goes to WB.
REQ-018 MEM: mem_req=1 and mem_we=(op==SW) every cycle until mem_ack=1; on ack, mem_req drops next cycle and the FSM moves to WB.
REQ-019 WB lasts one cycle; reg_write=1 only in WB and only for R_TYPE, LI, LW, SHIFT, JAL; pc_en=1; next state IDLE.
REQ-020 alu_src_imm, mem_to_reg, branch, jump, is_jal, update_flags are driven from the latched opcode; stable from EXEC through WB; 0 in IDLE.
REQ-021 Latency: non-memory op, accept cycle N -> EXEC N+1 -> WB N+2 (pc_en) -> instr_ready N+3; memory op with ack in cycle M -> WB M+1.
REQ-022 Undefined opcodes execute as NOP: all controls 0, EXEC -> WB, pc_en pulses.
REQ-023 mem_ack outside MEM is ignored; ack in the first MEM cycle is legal (one-cycle MEM).
REQ-024 instr_valid is ignored while busy=1; opcode changes after acceptance have no effect.

Reset
REQ-025 reset=1 forces IDLE on the next edge, from any state, including mid-MEM.
REQ-026 While reset=1, all outputs read 0, including instr_ready; fault clears; the timeout counter clears.
REQ-027 instr_ready=1 in the first cycle after reset deasserts.
REQ-028 An outstanding memory request is abandoned on reset; a late mem_ack is ignored per REQ-023.

Configuration
REQ-029 Macro CTRL_MEM_TIMEOUT_EN selects the memory-timeout feature.
REQ-030 Defined: a counter runs in MEM; after MEM_TIMEOUT cycles without ack -> FAULT, with fault=1, mem_req=0, instr_ready=0, pc_en=0 until reset.
REQ-031 Undefined: no counter and no FAULT state; MEM waits indefinitely; fault tied 0.

Structure
REQ-032 Package definitions holds the opcode constants and a ctrl_state_t enum (IDLE, EXEC, MEM, WB, FAULT).
REQ-033 One combinational sub-module, ctrl_op_table, maps the latched opcode to the static control bits; multicycle_ctrl owns all sequencing.

Verification
REQ-034 LI accepted in cycle 0 -> alu_src_imm=1 in cycles 1-2; reg_write=1 and pc_en=1 in cycle 2 only; instr_ready=1 in cycle 3.
REQ-035 LW with mem_ack in the 4th MEM cycle -> mem_req=1 for exactly 4 cycles with mem_we=0; WB next cycle with reg_write=1 and mem_to_reg=1.
REQ-036 SW with same-cycle ack in the first MEM cycle -> mem_req=1 and mem_we=1 for one cycle; WB with reg_write=0 and pc_en=1.
REQ-037 OPCODE_W=4, opcode 4'hF -> all controls 0, pc_en pulses in cycle 2.
REQ-038 reset asserted during the 2nd MEM cycle -> next cycle IDLE, mem_req=0; a stray mem_ack afterwards causes no pc_en.
REQ-039 CTRL_MEM_TIMEOUT_EN defined, MEM_TIMEOUT=15, no ack -> fault=1 after 15 MEM cycles; instr_ready stays 0 until reset, then fault=0.
